// File: rtl/guess_level_ctrl.sv
// Level controller for the number-guessing game: level/round/miss tracking, per-level countdown, per-level limits.
// All outputs registered; one cycle from a sampled input. No backpressure: each confirm rising edge is acted on once.
module guess_level_ctrl #(
  parameter int NUM_LEVELS       = 3,
  parameter int ROUNDS_PER_LEVEL = 5,
  parameter int BASE_MISSES      = 3,
  parameter int TIMER_W          = 7,
  parameter int LEVEL_TIME       = 30
) (
  input  logic               clk,
  input  logic               restart,
  input  logic               sec_tick,
  input  logic               confirm,
  input  logic               guess_correct,
  output logic [2:0]         level,
  output logic [2:0]         max_digit,
  output logic [3:0]         max_misses,
  output logic [3:0]         round,
  output logic [3:0]         misses,
  output logic [TIMER_W-1:0] timer,
  output logic               level_up,
  output logic               game_over,
  output logic               game_won
);

  typedef enum logic [1:0] {S_PLAY, S_LVUP, S_WIN, S_OVER} state_t;

  localparam logic [2:0]         TOP_LEVEL = 3'(NUM_LEVELS);
  localparam logic [3:0]         LAST_RND  = 4'(ROUNDS_PER_LEVEL - 1);
  localparam logic [3:0]         RST_MM    = 4'(BASE_MISSES);
  localparam logic [TIMER_W-1:0] RST_TIMER = TIMER_W'(LEVEL_TIME);

  function automatic logic [TIMER_W-1:0] time_for(input logic [2:0] l);
    return TIMER_W'(LEVEL_TIME * int'(l));
  endfunction

  function automatic logic [3:0] limit_for(input logic [2:0] l);
    return RST_MM + {1'b0, l} - 4'd1;
  endfunction

  state_t             state, state_n;
  logic               confirm_q;
  logic               cfm_edge;
  logic [2:0]         level_n, max_digit_n;
  logic [3:0]         max_misses_n, round_n, misses_n;
  logic [TIMER_W-1:0] timer_n;
  logic               level_up_n, game_over_n, game_won_n;

  assign cfm_edge = confirm & ~confirm_q;

  always_comb begin
    state_n      = state;
    level_n      = level;
    round_n      = round;
    misses_n     = misses;
    timer_n      = timer;
    max_misses_n = max_misses;
    max_digit_n  = max_digit;
    level_up_n   = 1'b0;
    game_over_n  = game_over;
    game_won_n   = game_won;

    case (state)
      S_PLAY: begin
        if (timer == '0) begin
          state_n      = S_OVER;
          game_over_n  = 1'b1;
          max_digit_n  = 3'd0;
          max_misses_n = 4'd0;
        end else begin
          if (sec_tick) timer_n = timer - 1'b1;
          if (cfm_edge && guess_correct) begin
            if (round == LAST_RND) begin
              if (level == TOP_LEVEL) begin
                state_n      = S_WIN;
                game_won_n   = 1'b1;
                max_digit_n  = 3'd0;
                max_misses_n = 4'd0;
              end else begin
                // Level-up values are applied on entry so LVUP already shows the new level.
                state_n      = S_LVUP;
                level_n      = level + 3'd1;
                round_n      = 4'd0;
                misses_n     = 4'd0;
                timer_n      = time_for(level + 3'd1);
                max_misses_n = limit_for(level + 3'd1);
                max_digit_n  = level + 3'd1;
                level_up_n   = 1'b1;
              end
            end else begin
              round_n = round + 4'd1;
            end
          end else if (cfm_edge) begin
            misses_n = misses + 4'd1;
            if (misses + 4'd1 == max_misses) begin
              state_n      = S_OVER;
              game_over_n  = 1'b1;
              max_digit_n  = 3'd0;
              max_misses_n = 4'd0;
            end
          end
        end
      end
      S_LVUP: state_n = S_PLAY;
      S_WIN, S_OVER: begin
        if (cfm_edge) begin
          state_n      = S_PLAY;
          level_n      = 3'd1;
          round_n      = 4'd0;
          misses_n     = 4'd0;
          timer_n      = RST_TIMER;
          max_misses_n = RST_MM;
          max_digit_n  = 3'd1;
          game_over_n  = 1'b0;
          game_won_n   = 1'b0;
        end
      end
      default: state_n = S_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    // Tracks confirm even during restart so a held button yields no edge afterwards.
    confirm_q <= confirm;
    if (restart) begin
      state      <= S_PLAY;
      level      <= 3'd1;
      round      <= 4'd0;
      misses     <= 4'd0;
      timer      <= RST_TIMER;
      max_misses <= RST_MM;
      max_digit  <= 3'd1;
      level_up   <= 1'b0;
      game_over  <= 1'b0;
      game_won   <= 1'b0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      round      <= round_n;
      misses     <= misses_n;
      timer      <= timer_n;
      max_misses <= max_misses_n;
      max_digit  <= max_digit_n;
      level_up   <= level_up_n;
      game_over  <= game_over_n;
      game_won   <= game_won_n;
    end
  end

endmodule

// File: tb/tb_guess_level_ctrl.sv
// Bench for guess_level_ctrl: directed game scenarios followed by random play, checked against a behavioural game model.
module tb_guess_level_ctrl;

  localparam int NL  = 3;
  localparam int RPL = 5;
  localparam int BM  = 3;
  localparam int LT  = 30;
  localparam int TW  = 7;

  localparam int PH_PLAY = 0;
  localparam int PH_LVUP = 1;
  localparam int PH_WIN  = 2;
  localparam int PH_OVER = 3;

  logic          clk = 1'b0;
  logic          restart = 1'b0, sec_tick = 1'b0, confirm = 1'b0, guess_correct = 1'b0;
  logic [2:0]    level, max_digit;
  logic [3:0]    max_misses, round, misses;
  logic [TW-1:0] timer;
  logic          level_up, game_over, game_won;

  guess_level_ctrl #(
    .NUM_LEVELS(NL), .ROUNDS_PER_LEVEL(RPL), .BASE_MISSES(BM), .TIMER_W(TW), .LEVEL_TIME(LT)
  ) dut (
    .clk(clk), .restart(restart), .sec_tick(sec_tick), .confirm(confirm),
    .guess_correct(guess_correct), .level(level), .max_digit(max_digit),
    .max_misses(max_misses), .round(round), .misses(misses), .timer(timer),
    .level_up(level_up), .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int lu_seen  = 0;

  // Game model: phase, counters, and the previous confirm level.
  int m_ph, m_lvl, m_rnd, m_mis, m_tmr, m_lu;
  bit m_cq;

  task automatic model_reset();
    m_ph = PH_PLAY; m_lvl = 1; m_rnd = 0; m_mis = 0; m_tmr = LT; m_lu = 0;
  endtask

  task automatic model_step(input bit r, input bit t, input bit c, input bit g);
    bit rise;
    rise = c && !m_cq;
    m_cq = c;
    m_lu = 0;
    if (r) begin
      model_reset();
      return;
    end
    if (m_ph == PH_PLAY) begin
      if (m_tmr == 0) m_ph = PH_OVER;
      else begin
        if (t) m_tmr = m_tmr - 1;
        if (rise && g) begin
          if (m_rnd + 1 == RPL) begin
            if (m_lvl == NL) m_ph = PH_WIN;
            else begin
              m_lvl = m_lvl + 1; m_rnd = 0; m_mis = 0;
              m_tmr = LT * m_lvl; m_ph = PH_LVUP; m_lu = 1;
            end
          end else m_rnd = m_rnd + 1;
        end else if (rise) begin
          m_mis = m_mis + 1;
          if (m_mis == BM + m_lvl - 1) m_ph = PH_OVER;
        end
      end
    end else if (m_ph == PH_LVUP) m_ph = PH_PLAY;
    else if (rise) model_reset();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit live;
    live = (m_ph == PH_PLAY) || (m_ph == PH_LVUP);
    chk({tag, ".level"},      int'(level),      m_lvl);
    chk({tag, ".round"},      int'(round),      m_rnd);
    chk({tag, ".misses"},     int'(misses),     m_mis);
    chk({tag, ".timer"},      int'(timer),      m_tmr);
    chk({tag, ".max_digit"},  int'(max_digit),  live ? m_lvl : 0);
    chk({tag, ".max_misses"}, int'(max_misses), live ? BM + m_lvl - 1 : 0);
    chk({tag, ".level_up"},   int'(level_up),   m_lu);
    chk({tag, ".game_over"},  int'(game_over),  (m_ph == PH_OVER) ? 1 : 0);
    chk({tag, ".game_won"},   int'(game_won),   (m_ph == PH_WIN) ? 1 : 0);
  endtask

  task automatic step(input string tag, input bit r, input bit t, input bit c, input bit g);
    restart = r; sec_tick = t; confirm = c; guess_correct = g;
    @(posedge clk);
    model_step(r, t, c, g);
    #1;
    if (level_up === 1'b1) lu_seen++;
    check_all(tag);
  endtask

  task automatic press(input string tag, input bit g);
    step(tag, 1'b0, 1'b0, 1'b1, g);
    step(tag, 1'b0, 1'b0, 1'b0, g);
  endtask

  initial begin
    bit cur_c;
    m_cq = 1'b0;
    model_reset();
    #1;

    // Reset with the button held: no edge once released from reset.
    step("rst0", 1, 0, 1, 0);
    step("rst1", 1, 0, 1, 0);
    step("rst_hold", 0, 0, 1, 1);
    chk("rst_level", int'(level), 1);
    chk("rst_timer", int'(timer), 30);
    chk("rst_maxm", int'(max_misses), 3);
    chk("rst_maxd", int'(max_digit), 1);
    chk("rst_round_held", int'(round), 0);
    step("rst_fall", 0, 0, 0, 1);
    step("rst_rise", 0, 0, 1, 1);
    chk("rst_round_rise", int'(round), 1);

    // Full win.
    step("w_rst", 1, 0, 0, 0);
    lu_seen = 0;
    for (int i = 0; i < 15; i++) begin
      press("win", 1);
      if (i == 4) chk("win_t60", int'(timer), 60);
      if (i == 4) chk("win_mm4", int'(max_misses), 4);
      if (i == 9) chk("win_t90", int'(timer), 90);
      if (i == 9) chk("win_mm5", int'(max_misses), 5);
    end
    chk("win_flag", int'(game_won), 1);
    chk("win_maxd", int'(max_digit), 0);
    chk("win_lu_count", lu_seen, 2);

    // Soft restart from WIN, then the miss limit.
    press("soft", 1);
    chk("soft_level", int'(level), 1);
    press("miss", 0);
    press("miss", 0);
    press("miss", 1);
    chk("miss2", int'(misses), 2);
    chk("miss_rnd1", int'(round), 1);
    chk("miss_play", int'(game_over), 0);
    press("miss3", 0);
    chk("miss_over", int'(game_over), 1);
    chk("miss_mm0", int'(max_misses), 0);

    // Timer expiry with a confirm in the zero-timer cycle.
    step("t_rst", 1, 0, 0, 0);
    for (int i = 0; i < 30; i++) step("tick", 0, 1, 0, 0);
    chk("t_zero", int'(timer), 0);
    chk("t_not_over_yet", int'(game_over), 0);
    step("t_cfm", 0, 0, 1, 1);
    chk("t_round_kept", int'(round), 0);
    chk("t_over", int'(game_over), 1);
    step("t_rel", 0, 0, 0, 0);

    // Final tick coinciding with a level-clearing guess.
    step("tb_rst", 1, 0, 0, 0);
    for (int i = 0; i < 29; i++) step("tb_tick", 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) press("tb_rnd", 1);
    chk("tb_t1", int'(timer), 1);
    step("tie", 0, 1, 1, 1);
    chk("tie_level", int'(level), 2);
    chk("tie_timer", int'(timer), 60);
    chk("tie_lu", int'(level_up), 1);
    chk("tie_no_over", int'(game_over), 0);
    step("tie_rel", 0, 0, 0, 0);
    press("l2", 1);
    chk("l2_round", int'(round), 1);

    // Restart mid-round at level 2.
    step("mid_rst", 1, 0, 0, 0);
    chk("mid_level", int'(level), 1);
    chk("mid_round", int'(round), 0);
    chk("mid_timer", int'(timer), 30);

    // Random play.
    cur_c = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bit r, t, g;
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 3) == 0);
      g = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) == 0) cur_c = ~cur_c;
      step("rand", r, t, cur_c, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
